bus_to_st_unpack: RTL
=====================

Name: bus_to_st_unpack

Overview:
- Parallel-bus to Avalon-ST converter for the turbo decoder input path: bus words (from memory, already in clk_st domain via upstream dual-clock FIFO) are unpacked into ST-bit stream beats feeding TurboDecoder.
- Mirror of the decoder-output packer: beat 0 of each bus word occupies bits [ST-1:0]; the last beat occupies the MSBs.
- Frames beats into turbo packets of BUS_PER_PKT words with sop/eop; 2-entry word buffer allows continuous one-beat-per-cycle streaming.

Parameters:
ST_PER_BUS, 512, bus word width in bits
ST, 8, stream beat width in bits
BEATS_PER_BUS, 64, ST_PER_BUS/ST
BUS_PER_PKT, 2, bus words per turbo packet (1024-len: 128 beats)

Ports:
clk_st  in  1  clock
rst_n  in  1  synchronous, active-low reset
bus_data  in  ST_PER_BUS  input bus word
bus_valid  in  1  bus_data valid
bus_ready  out  1  block can accept a word this cycle
st_data  out  ST  stream beat
st_valid  out  1  beat valid
st_sop  out  1  first beat of packet
st_eop  out  1  last beat of packet
st_ready  in  1  decoder accepts beat (ready latency 0)
pkt_done  out  1  one-cycle pulse when eop beat transfers

Behaviour:
- Reset (rst_n=0 at clk_st edge): buffer count=0, wr/rd ptr=0, beat_cnt=0, bus_cnt=0, rdy_en=0, pkt_done=0. Outputs: bus_ready=0, st_valid=0, st_sop=0, st_eop=0, st_data=0.
- rdy_en set 1 on first cycle after reset release; bus_ready = rdy_en && (count!=2); depends only on registers, never combinationally on bus_valid/st_ready.
- Push: bus_valid && bus_ready -> entry[wr_ptr]<=bus_data, wr_ptr toggles.
- Output: st_valid = (count!=0); st_data = entry[rd_ptr][beat_cnt*ST +: ST]; st_data forced 0 when count==0.
- Transfer: st_valid && st_ready. On transfer beat_cnt increments; at BEATS_PER_BUS-1 it wraps to 0, rd_ptr toggles (pop), bus_cnt increments, wrapping to 0 at BUS_PER_PKT-1.
- st_sop = st_valid && bus_cnt==0 && beat_cnt==0. st_eop = st_valid && bus_cnt==BUS_PER_PKT-1 && beat_cnt==BEATS_PER_BUS-1.
- pkt_done registered: 1 for exactly one cycle following the eop transfer.
- Counter widths: beat_cnt clog2(BEATS_PER_BUS), bus_cnt max(1,clog2(BUS_PER_PKT)), count 2 bits.
- Latency: word pushed in cycle N -> its beat 0 valid in cycle N+1 when buffer was empty.
- Simultaneous push and pop in the same cycle: count unchanged, no bubble; next word's beat 0 presented the cycle after the pop.
- Full (count==2): bus_ready=0 even if a pop occurs that cycle (no bypass); reasserts the following cycle.
- st_ready=0: st_data/st_sop/st_eop held stable, counters frozen.
- Reset mid-packet: all buffered data discarded; first word after reset begins a new packet (sop asserted on its beat 0).
- No bus-side framing input: packet boundaries are derived purely from word count since reset.
- Throughput: one beat/cycle sustained when bus supplies one word per BEATS_PER_BUS cycles.

Test Plan:
- Single packet, st_ready=1: W0 beats 0x00..0x3F, W1 beats 0x40..0x7F -> 128 consecutive beats 0x00..0x7F; sop only on 0x00 (cycle after W0 push), eop only on 0x7F, pkt_done single pulse the cycle after 0x7F.
- Full buffer: bus_valid held 1, st_ready=0 -> exactly 2 words accepted, bus_ready=0 from the next cycle; st_data=0x00, st_valid=1, st_sop=1 held stable.
- Backpressure: st_ready toggles 1/0 each cycle over one packet -> 128 beats transfer in 255-256 cycles, order 0x00..0x7F intact, no duplicated or dropped beats.
- Back-to-back: 4 words presented continuously, st_ready=1 -> 256 gapless beats, sop at beats 0 and 128, eop at beats 127 and 255, two pkt_done pulses.
- Simultaneous push/pop: count==1, W1 pushed in the same cycle as W0's beat 63 transfers -> count stays 1, W1 beat 0 valid the next cycle, no st_valid gap.
- Reset mid-packet after 70 beats -> st_valid=0 and bus_ready=0 during reset, bus_ready=1 one cycle after release; next word's beat 0 carries sop, and its second word's beat 63 carries eop.

Source files
------------

// File: rtl/bus_to_st_unpack.sv
// Unpacks wide bus words into narrow stream beats, LSB beat first, framing
// every BUS_PER_PKT words as one packet with sop/eop and a pkt_done pulse.
module bus_to_st_unpack #(
    parameter int unsigned ST_PER_BUS  = 512,
    parameter int unsigned ST          = 8,
    parameter int unsigned BUS_PER_PKT = 2
) (
    input  logic                  clk_st,
    input  logic                  rst_n,
    input  logic [ST_PER_BUS-1:0] bus_data,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    output logic [ST-1:0]         st_data,
    output logic                  st_valid,
    output logic                  st_sop,
    output logic                  st_eop,
    input  logic                  st_ready,
    output logic                  pkt_done
);

    localparam int unsigned BEATS_PER_BUS = ST_PER_BUS / ST;
    localparam int unsigned BEAT_W = (BEATS_PER_BUS > 1) ? $clog2(BEATS_PER_BUS) : 1;
    localparam int unsigned BUS_W  = (BUS_PER_PKT > 1) ? $clog2(BUS_PER_PKT) : 1;
    localparam int unsigned SH_W   = $clog2(ST_PER_BUS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BUS - 1);
    localparam logic [BUS_W-1:0]  LAST_BUS  = BUS_W'(BUS_PER_PKT - 1);

    logic [ST_PER_BUS-1:0] entry_q [2];
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [BUS_W-1:0]      bus_cnt_q, bus_cnt_d;
    logic                  rdy_en_q, rdy_en_d;
    logic                  pkt_done_q, pkt_done_d;

    logic                  push_c;
    logic                  xfer_c;
    logic                  pop_c;
    logic [ST_PER_BUS-1:0] cur_word_c;

    // Stream outputs are pure functions of registered state.
    always_comb begin
        bus_ready  = rdy_en_q && (count_q != 2'd2);
        st_valid   = (count_q != 2'd0);
        cur_word_c = entry_q[rd_ptr_q];
        st_data    = '0;
        if (st_valid) begin
            st_data = ST'(cur_word_c >> (SH_W'(beat_cnt_q) * SH_W'(ST)));
        end
        st_sop   = st_valid && (bus_cnt_q == '0) && (beat_cnt_q == '0);
        st_eop   = st_valid && (bus_cnt_q == LAST_BUS) && (beat_cnt_q == LAST_BEAT);
        pkt_done = pkt_done_q;
    end

    // Handshakes and next-state for buffer pointers and framing counters.
    always_comb begin
        push_c     = bus_valid && bus_ready;
        xfer_c     = st_valid && st_ready;
        pop_c      = xfer_c && (beat_cnt_q == LAST_BEAT);
        count_d    = count_q + 2'(push_c) - 2'(pop_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        bus_cnt_d  = bus_cnt_q;
        rdy_en_d   = 1'b1;
        pkt_done_d = xfer_c && st_eop;
        if (push_c) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (xfer_c) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
        if (pop_c) begin
            beat_cnt_d = '0;
            rd_ptr_d   = ~rd_ptr_q;
            bus_cnt_d  = (bus_cnt_q == LAST_BUS) ? '0 : bus_cnt_q + BUS_W'(1);
        end
    end

    always_ff @(posedge clk_st) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
            bus_cnt_q  <= '0;
            rdy_en_q   <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            bus_cnt_q  <= bus_cnt_d;
            rdy_en_q   <= rdy_en_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // Word storage carries no reset; st_data is masked while the buffer is empty.
    always_ff @(posedge clk_st) begin
        if (rst_n && push_c) begin
            entry_q[wr_ptr_q] <= bus_data;
        end
    end

endmodule
